// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared constants and parameter helpers for sync_fifo_thresh
package sync_fifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;

  function automatic int cntr_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  function automatic bit params_ok(input int depth, input int af_level, input int ae_level);
    return (depth >= 2) && (af_level >= 1) && (af_level <= depth) &&
           (ae_level >= 0) && (ae_level <= depth - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// rtl/sync_fifo_ram.sv - FIFO storage, one write port and one registered read port
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = ptr_width(DEF_DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             WR_EN,
  input  logic [AW-1:0]    WR_ADDR,
  input  logic [WIDTH-1:0] WR_DATA,
  input  logic             RD_EN,
  input  logic [AW-1:0]    RD_ADDR,
  output logic [WIDTH-1:0] RD_DATA
);

  logic [WIDTH-1:0] mem [DEPTH];

  // The array itself is never reset; only the output register is.
  always_ff @(posedge CLK) begin
    if (WR_EN) mem[WR_ADDR] <= WR_DATA;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)       RD_DATA <= '0;
    else if (RD_EN) RD_DATA <= mem[RD_ADDR];
  end

endmodule

// File: rtl/sync_fifo_thresh.sv
// rtl/sync_fifo_thresh.sv - single-clock FIFO with almost-full/empty thresholds and read-valid
// Optional OVERFLOW/UNDERFLOW pulses enabled by SYNC_FIFO_ERR_FLAGS_EN.
module sync_fifo_thresh
  import sync_fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = DEF_WIDTH,
  parameter int FIFO_DEPTH = DEF_DEPTH,
  parameter int AF_LEVEL   = FIFO_DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic [FIFO_WIDTH-1:0]              DATA_IN,
  input  logic                               WR_EN,
  input  logic                               RD_EN,
  output logic [FIFO_WIDTH-1:0]              DATA_OUT,
  output logic                               RD_VALID,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    CNTR,
  output logic                               EMPTY,
  output logic                               FULL,
  output logic                               ALMOST_EMPTY,
  output logic                               ALMOST_FULL,
  output logic                               OVERFLOW,
  output logic                               UNDERFLOW
);

  localparam int CW = cntr_width(FIFO_DEPTH);
  localparam int PW = ptr_width(FIFO_DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

  if (!params_ok(FIFO_DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_param_err
    $error("sync_fifo_thresh: FIFO_DEPTH must be >= 2 and thresholds within range");
  end

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          wr_acc;
  logic          rd_acc;

  // Explicit wrap so non-power-of-two depths never index past the last entry.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign wr_acc = WR_EN && !FULL;
  assign rd_acc = RD_EN && !EMPTY;

  assign EMPTY        = (CNTR == '0);
  assign FULL         = (CNTR == FULL_CNT);
  assign ALMOST_EMPTY = (CNTR <= AE_CNT);
  assign ALMOST_FULL  = (CNTR >= AF_CNT);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      CNTR     <= '0;
      RD_VALID <= 1'b0;
    end else begin
      RD_VALID <= rd_acc;
      if (wr_acc) wr_ptr <= next_ptr(wr_ptr);
      if (rd_acc) rd_ptr <= next_ptr(rd_ptr);
      case ({wr_acc, rd_acc})
        2'b10:   CNTR <= CNTR + CW'(1);
        2'b01:   CNTR <= CNTR - CW'(1);
        default: CNTR <= CNTR;
      endcase
    end
  end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      OVERFLOW  <= 1'b0;
      UNDERFLOW <= 1'b0;
    end else begin
      OVERFLOW  <= WR_EN && FULL;
      UNDERFLOW <= RD_EN && EMPTY;
    end
  end
`else
  assign OVERFLOW  = 1'b0;
  assign UNDERFLOW = 1'b0;
`endif

  sync_fifo_ram #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .AW    (PW)
  ) u_ram (
    .CLK     (CLK),
    .RST     (RST),
    .WR_EN   (wr_acc),
    .WR_ADDR (wr_ptr),
    .WR_DATA (DATA_IN),
    .RD_EN   (rd_acc),
    .RD_ADDR (rd_ptr),
    .RD_DATA (DATA_OUT)
  );

endmodule
